// File: rtl/riscv_pkg.sv
// riscv_pkg - shared integer-core defaults.
//   XLEN / NREGS / ADDR : default register width, register count, address width
//   reg_addr_t / xlen_t : register address and data types
//   addr_in_range       : true when an address names an implemented register
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int ADDR  = $clog2(NREGS);

  typedef logic [ADDR-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  // Addresses at or above nregs exist only when nregs is not a power of two;
  // they behave as unimplemented registers.
  function automatic logic addr_in_range(input logic [31:0] addr, input int nregs);
    return addr < 32'(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard - one busy bit per architectural register.
//   clk, rst        : clock, synchronous active-high reset
//   iss_valid/iss_rd: destination of the instruction issued this cycle (sets busy)
//   we/wa           : writeback ports (clear busy)
//   busy            : current busy bits, busy[0] is always 0
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int ADDR  = $clog2(NREGS),
  parameter int NWR   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [ADDR-1:0]  iss_rd,
  input  logic [NWR-1:0]   we,
  input  logic [ADDR-1:0]  wa [NWR],
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && addr_in_range(32'(wa[j]), NREGS)) busy_next[wa[j]] = 1'b0;
    end
    // Set is applied after clear: a newly issued producer must stay tracked
    // even if an older producer of the same register retires this cycle.
    if (iss_valid && iss_rd != '0 && addr_in_range(32'(iss_rd), NREGS)) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp - multi-port integer register file with busy-bit scoreboard.
//   clk, rst   : clock, synchronous active-high reset
//   rs_addr    : NRD read addresses
//   rs_data    : NRD combinational read data
//   rs_busy    : addressed register still has an outstanding producer
//   rs_valid   : read port used by the instruction in decode
//   stall      : some used read port is busy
//   iss_valid  : issue with destination iss_rd this cycle
//   we, wa, wd : NWR write ports, higher index wins on address collision
module regfile_mp
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter int ADDR   = $clog2(NREGS),
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ADDR-1:0] rs_addr [NRD],
  output logic [XLEN-1:0] rs_data [NRD],
  output logic [NRD-1:0]  rs_busy,
  input  logic [NRD-1:0]  rs_valid,
  output logic            stall,
  input  logic            iss_valid,
  input  logic [ADDR-1:0] iss_rd,
  input  logic [NWR-1:0]  we,
  input  logic [ADDR-1:0] wa [NWR],
  input  logic [XLEN-1:0] wd [NWR]
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NRD-1:0]   fwd_hit;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .ADDR  (ADDR),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .we        (we),
    .wa        (wa),
    .busy      (busy)
  );

  // Ports are visited in ascending order so the last nonblocking assignment,
  // i.e. the highest port index, wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && wa[j] != '0 && addr_in_range(32'(wa[j]), NREGS)) begin
          regs[wa[j]] <= wd[j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rs_data[i] = '0;
      rs_busy[i] = 1'b0;
      fwd_hit[i] = 1'b0;
      if (rs_addr[i] != '0 && addr_in_range(32'(rs_addr[i]), NREGS)) begin
        rs_data[i] = regs[rs_addr[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (we[j] && wa[j] == rs_addr[i]) begin
              rs_data[i] = wd[j];
              fwd_hit[i] = 1'b1;
            end
          end
        end
        // A forwarded value satisfies the consumer, so it need not wait.
        rs_busy[i] = busy[rs_addr[i]] & ~fwd_hit[i];
      end
    end
  end

  always_comb begin
    stall = |(rs_valid & rs_busy);
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr [2];
  logic [31:0] rs_data_b [2];
  logic [31:0] rs_data_nb [2];
  logic [1:0]  rs_busy_b, rs_busy_nb;
  logic [1:0]  rs_valid;
  logic        stall_b, stall_nb;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [1:0]  we;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .rs_valid(rs_valid), .stall(stall_b), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .we(we), .wa(wa), .wd(wd)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_busy(rs_busy_nb),
    .rs_valid(rs_valid), .stall(stall_nb), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .we(we), .wa(wa), .wd(wd)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit model_ok = 1'b0;

  // Reference state: architectural contents and outstanding-producer flags.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_mem[a];
    if (byp) for (int j = 0; j < 2; j++) if (we[j] && wa[j] == a) v = wd[j];
    return v;
  endfunction

  function automatic bit m_rbusy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp) for (int j = 0; j < 2; j++) if (we[j] && wa[j] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic m_update();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  = 32'h0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) if (we[j] && wa[j] != 0) m_mem[wa[j]] = wd[j];
      for (int j = 0; j < 2; j++) if (we[j]) m_busy[wa[j]] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic step(input string tag, input bit chk, input logic [31:0] eb,
                      input logic [31:0] enb, input bit esb, input bit esnb);
    bit sb, snb;
    #1;
    if (chk) begin
      cmp({tag, " data0 bypass"},   rs_data_b[0],  eb);
      cmp({tag, " data0 nobypass"}, rs_data_nb[0], enb);
      cmp({tag, " stall bypass"},   32'(stall_b),  32'(esb));
      cmp({tag, " stall nobypass"}, 32'(stall_nb), 32'(esnb));
    end
    if (model_ok) begin
      sb = 1'b0;
      snb = 1'b0;
      for (int i = 0; i < 2; i++) begin
        cmp({tag, " model data b"},  rs_data_b[i],         m_read(rs_addr[i], 1'b1));
        cmp({tag, " model data nb"}, rs_data_nb[i],        m_read(rs_addr[i], 1'b0));
        cmp({tag, " model busy b"},  32'(rs_busy_b[i]),    32'(m_rbusy(rs_addr[i], 1'b1)));
        cmp({tag, " model busy nb"}, 32'(rs_busy_nb[i]),   32'(m_rbusy(rs_addr[i], 1'b0)));
        sb  |= rs_valid[i] & m_rbusy(rs_addr[i], 1'b1);
        snb |= rs_valid[i] & m_rbusy(rs_addr[i], 1'b0);
      end
      cmp({tag, " model stall b"},  32'(stall_b),  32'(sb));
      cmp({tag, " model stall nb"}, 32'(stall_nb), 32'(snb));
    end
    @(posedge clk);
    m_update();
    if (rst) model_ok = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    bit        rst;
    bit [1:0]  we;
    bit [4:0]  wa0, wa1;
    bit [31:0] wd0, wd1;
    bit        iv;
    bit [4:0]  ird;
    bit [4:0]  ra0;
    bit        rv0;
    bit        chk;
    bit [31:0] eb, enb;
    bit        esb, esnb;
  } vec_t;

  vec_t vecs [25];

  initial begin
    //          rst we    wa0 wa1 wd0           wd1    iv ird ra0 rv0 chk eb            enb           esb esnb
    vecs[0]  = '{1, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  0,  0,  0, 32'h0,        32'h0,        0, 0};
    // reset scenario: load x5 and mark it busy, then reset
    vecs[1]  = '{0, 2'b01, 5, 0, 32'hDEADBEEF, 32'h0, 1, 5,  5,  1,  1, 32'hDEADBEEF, 32'h0,        0, 0};
    vecs[2]  = '{1, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  5,  1,  1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1};
    vecs[3]  = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  5,  1,  1, 32'h0,        32'h0,        0, 0};
    // x0 stays zero
    vecs[4]  = '{0, 2'b01, 0, 0, 32'hFFFFFFFF, 32'h0, 1, 0,  0,  1,  1, 32'h0,        32'h0,        0, 0};
    vecs[5]  = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  0,  1,  1, 32'h0,        32'h0,        0, 0};
    // bypass on x7
    vecs[6]  = '{0, 2'b01, 7, 0, 32'h11,       32'h0, 0, 0,  7,  0,  1, 32'h11,       32'h0,        0, 0};
    vecs[7]  = '{0, 2'b01, 7, 0, 32'h22,       32'h0, 0, 0,  7,  0,  1, 32'h22,       32'h11,       0, 0};
    vecs[8]  = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  7,  0,  1, 32'h22,       32'h22,       0, 0};
    // dual write to x9, port 1 wins
    vecs[9]  = '{0, 2'b11, 9, 9, 32'hA,        32'hB, 0, 0,  9,  0,  1, 32'hB,        32'h0,        0, 0};
    vecs[10] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  9,  0,  1, 32'hB,        32'hB,        0, 0};
    // scoreboard on x3
    vecs[11] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 1, 3,  3,  1,  1, 32'h0,        32'h0,        0, 0};
    vecs[12] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  3,  1,  1, 32'h0,        32'h0,        1, 1};
    vecs[13] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  3,  1,  1, 32'h0,        32'h0,        1, 1};
    vecs[14] = '{0, 2'b01, 3, 0, 32'h33,       32'h0, 0, 0,  3,  1,  1, 32'h33,       32'h0,        0, 1};
    vecs[15] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  3,  1,  1, 32'h33,       32'h33,       0, 0};
    vecs[16] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 1, 3,  3,  1,  1, 32'h33,       32'h33,       0, 0};
    vecs[17] = '{0, 2'b01, 3, 0, 32'h44,       32'h0, 1, 3,  3,  1,  1, 32'h44,       32'h33,       0, 1};
    vecs[18] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  3,  1,  1, 32'h44,       32'h44,       1, 1};
    vecs[19] = '{0, 2'b01, 3, 0, 32'h55,       32'h0, 0, 0,  3,  1,  1, 32'h55,       32'h44,       0, 1};
    // reset mid-operation with x4/x6 busy and a write to x4 in the reset cycle
    vecs[20] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 1, 4,  4,  1,  1, 32'h0,        32'h0,        0, 0};
    vecs[21] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 1, 6,  4,  1,  1, 32'h0,        32'h0,        1, 1};
    vecs[22] = '{1, 2'b01, 4, 0, 32'h99,       32'h0, 1, 6,  6,  1,  1, 32'h0,        32'h0,        1, 1};
    vecs[23] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  4,  1,  1, 32'h0,        32'h0,        0, 0};
    vecs[24] = '{0, 2'b00, 0, 0, 32'h0,        32'h0, 0, 0,  6,  1,  1, 32'h0,        32'h0,        0, 0};

    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = 32'h0;
      m_busy[r] = 1'b0;
    end
    rst = 1'b1; we = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    iss_valid = 1'b0; iss_rd = '0; rs_addr[0] = '0; rs_addr[1] = '0; rs_valid = '0;
    @(negedge clk);

    for (int k = 0; k < 25; k++) begin
      rst        = vecs[k].rst;
      we         = vecs[k].we;
      wa[0]      = vecs[k].wa0;
      wa[1]      = vecs[k].wa1;
      wd[0]      = vecs[k].wd0;
      wd[1]      = vecs[k].wd1;
      iss_valid  = vecs[k].iv;
      iss_rd     = vecs[k].ird;
      rs_addr[0] = vecs[k].ra0;
      rs_addr[1] = vecs[k].ra0 ^ 5'd1;
      rs_valid   = {1'b0, vecs[k].rv0};
      step($sformatf("vec%0d", k), vecs[k].chk, vecs[k].eb, vecs[k].enb,
           vecs[k].esb, vecs[k].esnb);
    end

    for (int k = 0; k < 600; k++) begin
      rst        = ($urandom_range(0, 63) == 0);
      we         = 2'($urandom_range(0, 3));
      wa[0]      = 5'($urandom_range(0, (k % 4 == 0) ? 31 : 7));
      wa[1]      = 5'($urandom_range(0, 7));
      wd[0]      = $urandom;
      wd[1]      = $urandom;
      iss_valid  = 1'($urandom_range(0, 1));
      iss_rd     = 5'($urandom_range(0, 7));
      rs_addr[0] = 5'($urandom_range(0, 7));
      rs_addr[1] = 5'($urandom_range(0, (k % 3 == 0) ? 31 : 7));
      rs_valid   = 2'($urandom_range(0, 3));
      step("rand", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
